// File: rtl/proc_run_ctrl_pkg.sv
// Shared types and default parameter values for the processor run controller.
// The state encoding is fixed at 3 bits so it stays stable across builds and
// can be probed directly in waveforms or by external debug logic.
package proc_run_ctrl_pkg;

    // Default parameter values used by proc_run_ctrl.
    localparam int DEF_NUM_CORES  = 1;
    localparam int DEF_RST_CYCLES = 2;
    localparam int DEF_MAX_CYCLES = 26;
    localparam int DEF_CNT_W      = 16;

    // Run controller state encoding.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESET   = 3'd1,
        ST_RUN     = 3'd2,
        ST_DONE    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_e;

    // A run is in progress while cores are being reset or are executing.
    function automatic logic is_active(input state_e s);
        return (s == ST_RESET) || (s == ST_RUN);
    endfunction

    // States in which a new run may be launched.
    function automatic logic is_launchable(input state_e s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_TIMEOUT);
    endfunction

endpackage

// File: rtl/proc_run_ctrl_halt_capture.sv
// Per-core halt capture: remembers whether the core has halted during the
// current run and the 1-based RUN cycle of its first halt. Later halts are
// ignored until the next run clears the record.
module proc_run_ctrl_halt_capture #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,       // synchronous, active-high
    input  logic             clr,       // new run accepted: forget previous halt
    input  logic             en,        // core enabled and controller in RUN
    input  logic             halt,      // core halt level
    input  logic [CNT_W-1:0] cnt_next,  // RUN cycle number being executed
    output logic             halted,
    output logic [CNT_W-1:0] cap
);

    logic             halted_q;
    logic [CNT_W-1:0] cap_q;

    // First-halt capture register; only the first halt of a run is recorded.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            halted_q <= 1'b0;
            cap_q    <= '0;
        end else if (en && halt && !halted_q) begin
            halted_q <= 1'b1;
            cap_q    <= cnt_next;
        end
    end

    assign halted = halted_q;
    assign cap    = cap_q;

endmodule

// File: rtl/proc_run_ctrl.sv
// Run controller for one or more processor cores. Holds the cores in reset
// for RST_CYCLES after a start, then releases the enabled cores, counts RUN
// cycles and records each core's first halt. A run finishes in DONE when
// every enabled core has halted, or in TIMEOUT when MAX_CYCLES RUN cycles
// pass without that. Every output is registered; core_rst changes on the
// same edge as the state transition that calls for it.
module proc_run_ctrl
    import proc_run_ctrl_pkg::*;
#(
    parameter int NUM_CORES  = DEF_NUM_CORES,
    parameter int RST_CYCLES = DEF_RST_CYCLES,
    parameter int MAX_CYCLES = DEF_MAX_CYCLES,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [NUM_CORES-1:0]       core_mask,
    input  logic [NUM_CORES-1:0]       core_halt,
    output logic [NUM_CORES-1:0]       core_rst,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout,
    output logic [CNT_W-1:0]           cycle_cnt,
    output logic [NUM_CORES*CNT_W-1:0] halt_cycle
);

    // Reset-phase counter only has to reach RST_CYCLES-1.
    localparam int                RC_W      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0]   RST_LAST  = RC_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(MAX_CYCLES);

    state_e                 state_q, state_d;
    logic [NUM_CORES-1:0]   mask_q, mask_d;
    logic [RC_W-1:0]        rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]       cycle_cnt_q, cycle_cnt_d;
    logic                   done_q, done_d;
    logic                   timeout_q, timeout_d;
    logic [NUM_CORES-1:0]   core_rst_q, core_rst_d;
    logic                   busy_q, busy_d;

    logic                   start_ok;   // start accepted this cycle
    logic                   run_live;   // RUN cycle that is not being aborted
    logic [CNT_W-1:0]       cnt_inc;    // number of the RUN cycle now executing
    logic [NUM_CORES-1:0]   halted;     // cores already captured this run
    logic [NUM_CORES-1:0]   new_cap;    // cores captured on this edge
    logic [NUM_CORES-1:0]   cap_en;

    assign cnt_inc  = cycle_cnt_q + CNT_W'(1);
    // An aborted RUN cycle is not counted and captures nothing, so the
    // counters keep the values they held before the abort.
    assign run_live = (state_q == ST_RUN) && !abort;
    assign cap_en   = mask_q & {NUM_CORES{run_live}};
    assign new_cap  = cap_en & core_halt & ~halted;

    // Next-state, counter and registered-output computation.
    always_comb begin
        // NOTE: every signal assigned here receives a default first, so no
        // path through the case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        mask_d      = mask_q;
        rst_cnt_d   = rst_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        done_d      = done_q;
        timeout_d   = timeout_q;
        start_ok    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                // A start with no enabled core is not a run; stay put.
                if (start && (core_mask != '0)) begin
                    start_ok    = 1'b1;
                    state_d     = ST_RESET;
                    mask_d      = core_mask;
                    rst_cnt_d   = '0;
                    cycle_cnt_d = '0;
                    done_d      = 1'b0;
                    timeout_d   = 1'b0;
                end
            end

            ST_RESET: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                end else if (rst_cnt_q == RST_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + RC_W'(1);
                end
            end

            ST_RUN: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                end else begin
                    cycle_cnt_d = cnt_inc;
                    // Full halt takes precedence over reaching the limit.
                    if ((halted | new_cap) == mask_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (cnt_inc == CNT_LIMIT) begin
                        state_d   = ST_TIMEOUT;
                        timeout_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs follow the state being entered so they switch on the
        // transition edge; disabled cores stay in reset throughout RUN.
        core_rst_d = (state_d == ST_RUN) ? ~mask_q : '1;
        busy_d     = is_active(state_d);
    end

    // State, counters and registered outputs; rst overrides every input.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before the edge, independent of order.
        if (rst) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            rst_cnt_q   <= '0;
            cycle_cnt_q <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            core_rst_q  <= '1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            rst_cnt_q   <= rst_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            core_rst_q  <= core_rst_d;
            busy_q      <= busy_d;
        end
    end

    // One first-halt recorder per core.
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
        proc_run_ctrl_halt_capture #(
            .CNT_W (CNT_W)
        ) u_halt_capture (
            .clk      (clk),
            .rst      (rst),
            .clr      (start_ok),
            .en       (cap_en[gi]),
            .halt     (core_halt[gi]),
            .cnt_next (cnt_inc),
            .halted   (halted[gi]),
            .cap      (halt_cycle[gi*CNT_W +: CNT_W])
        );
    end

    assign core_rst  = core_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Self-checking bench for proc_run_ctrl with four cores. Each run is
// described by a core mask and, per core, the RUN cycle of its first halt
// (0 = never). The expected outcome comes from a run-level model: the run
// ends at the latest first-halt among enabled cores, or at MAX_CYCLES if
// some enabled core never halts in time; an abort or reset cuts it short.
module tb_proc_run_ctrl;

    localparam int NC   = 4;
    localparam int RSTC = 2;
    localparam int MAXC = 26;
    localparam int CW   = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [NC-1:0]    core_mask;
    logic [NC-1:0]    core_halt;
    logic [NC-1:0]    core_rst;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CW-1:0]    cycle_cnt;
    logic [NC*CW-1:0] halt_cycle;

    int n_checks;
    int n_fail;
    int fh[NC];   // first-halt RUN cycle per core for the next run, 0 = never

    proc_run_ctrl #(
        .NUM_CORES  (NC),
        .RST_CYCLES (RSTC),
        .MAX_CYCLES (MAXC),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .core_mask  (core_mask),
        .core_halt  (core_halt),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .cycle_cnt  (cycle_cnt),
        .halt_cycle (halt_cycle)
    );

    always #5 clk = ~clk;

    // Natural end of a run: last first-halt cycle, or the limit.
    function automatic void model_end(input logic [NC-1:0] m, output int stop, output bit reaches_done);
        stop = 0;
        reaches_done = 1'b1;
        for (int i = 0; i < NC; i++) begin
            if (m[i]) begin
                if (fh[i] == 0 || fh[i] > MAXC) reaches_done = 1'b0;
                else if (fh[i] > stop) stop = fh[i];
            end
        end
        if (!reaches_done) stop = MAXC;
    endfunction

    // Launch one run and follow it cycle by cycle. Inputs are driven just
    // after a negedge; outputs are sampled on the following negedge.
    task automatic run_case(input logic [NC-1:0] mask, input int abort_at, input int rst_at, input string tag);
        int          stop;
        int          counted;
        int          exp_cnt;
        bit          nat_done;
        bit          exp_done;
        bit          exp_to;
        bit          by_rst;
        logic [NC*CW-1:0] exp_hc;
        logic [NC-1:0]    h;

        model_end(mask, stop, nat_done);
        by_rst   = 1'b0;
        exp_done = nat_done;
        exp_to   = !nat_done;
        counted  = stop;
        if (rst_at > 0 && rst_at <= stop) begin
            by_rst = 1'b1; stop = rst_at; counted = 0; exp_done = 0; exp_to = 0;
        end else if (abort_at > 0 && abort_at <= stop) begin
            stop = abort_at; counted = abort_at - 1; exp_done = 0; exp_to = 0;
        end
        exp_cnt = counted;
        exp_hc  = '0;
        for (int i = 0; i < NC; i++)
            if (mask[i] && fh[i] != 0 && fh[i] <= counted) exp_hc[i*CW +: CW] = CW'(fh[i]);

        // Accepted start: cores held in reset, previous results cleared.
        start = 1'b1; core_mask = mask; abort = 1'b0; core_halt = NC'($urandom);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || core_rst !== '1) begin
            n_fail++;
            $display("FAIL %s start: busy=%b core_rst=%b, want busy=1 core_rst=1111", tag, busy, core_rst);
        end
        n_checks++;
        if (done !== 1'b0 || timeout !== 1'b0 || cycle_cnt !== '0 || halt_cycle !== '0) begin
            n_fail++;
            $display("FAIL %s clear: done=%b timeout=%b cnt=%0d hc=%h, want all zero",
                     tag, done, timeout, cycle_cnt, halt_cycle);
        end

        // Reset phase: start, mask and halts must all be ignored.
        for (int k = 1; k <= RSTC; k++) begin
            start = 1'b1; core_mask = NC'($urandom); core_halt = NC'($urandom);
            @(negedge clk);
            n_checks++;
            if (k < RSTC && core_rst !== '1) begin
                n_fail++;
                $display("FAIL %s rst_phase%0d: core_rst=%b want 1111", tag, k, core_rst);
            end else if (k == RSTC && core_rst !== ~mask) begin
                n_fail++;
                $display("FAIL %s release: core_rst=%b want %b", tag, core_rst, ~mask);
            end
        end

        // RUN phase.
        for (int c = 1; c <= stop; c++) begin
            for (int i = 0; i < NC; i++) begin
                if (!mask[i])                       h[i] = 1'($urandom);
                else if (fh[i] == 0 || c < fh[i])   h[i] = 1'b0;
                else if (c == fh[i])                h[i] = 1'b1;
                else                                h[i] = 1'($urandom);
            end
            core_halt = h;
            core_mask = NC'($urandom);
            abort     = (c == abort_at);
            rst       = (c == rst_at);
            start     = (c == rst_at) ? 1'b1 : 1'($urandom);
            @(negedge clk);
            if (c < stop) begin
                n_checks++;
                if (busy !== 1'b1 || cycle_cnt !== CW'(c) || core_rst !== ~mask || done !== 1'b0 || timeout !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s run%0d: busy=%b cnt=%0d core_rst=%b done=%b to=%b, want 1 %0d %b 0 0",
                             tag, c, busy, cycle_cnt, core_rst, done, timeout, c, ~mask);
                end
            end
        end

        // End of run, then two idle cycles (one with abort) that must not disturb it.
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                rst = 1'b0; start = 1'b0; abort = (k == 1); core_halt = NC'($urandom);
                @(negedge clk);
            end
            n_checks++;
            if (busy !== 1'b0 || core_rst !== '1 || done !== exp_done || timeout !== exp_to) begin
                n_fail++;
                $display("FAIL %s end%0d: busy=%b core_rst=%b done=%b to=%b, want 0 1111 %b %b",
                         tag, k, busy, core_rst, done, timeout, exp_done, exp_to);
            end
            n_checks++;
            if (cycle_cnt !== CW'(exp_cnt) || halt_cycle !== exp_hc) begin
                n_fail++;
                $display("FAIL %s result%0d: cnt=%0d hc=%h, want cnt=%0d hc=%h",
                         tag, k, cycle_cnt, halt_cycle, exp_cnt, exp_hc);
            end
        end
        abort = 1'b0;
        if (by_rst) begin
            n_checks++;
            if (cycle_cnt !== '0 || halt_cycle !== '0) begin
                n_fail++;
                $display("FAIL %s rst_clear: cnt=%0d hc=%h want 0", tag, cycle_cnt, halt_cycle);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; abort = 1'b1; core_mask = '1; core_halt = '1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (core_rst !== '1 || busy !== 1'b0 || done !== 1'b0 || timeout !== 1'b0 ||
            cycle_cnt !== '0 || halt_cycle !== '0) begin
            n_fail++;
            $display("FAIL reset: core_rst=%b busy=%b done=%b to=%b cnt=%0d hc=%h, want 1111 0 0 0 0 0",
                     core_rst, busy, done, timeout, cycle_cnt, halt_cycle);
        end
        rst = 1'b0; start = 1'b0; abort = 1'b0; core_halt = '0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_single_done();
        fh = '{5, 0, 0, 0};
        run_case(4'b0001, 0, 0, "single_done");
    endtask

    // Runs right after single_done: a start with an empty mask changes nothing.
    task automatic test_mask_zero();
        start = 1'b1; core_mask = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b1 || cycle_cnt !== CW'(5) || halt_cycle[CW-1:0] !== CW'(5)) begin
            n_fail++;
            $display("FAIL mask_zero: busy=%b done=%b cnt=%0d hc0=%0d, want 0 1 5 5",
                     busy, done, cycle_cnt, halt_cycle[CW-1:0]);
        end
        start = 1'b0;
    endtask

    task automatic test_single_timeout();
        fh = '{0, 0, 0, 0};
        run_case(4'b0001, 0, 0, "single_timeout");
    endtask

    task automatic test_multi_core();
        fh = '{3, 7, 2, 9};
        run_case(4'b1011, 0, 0, "multi_core");
    endtask

    task automatic test_limit_tie();
        fh = '{26, 0, 0, 0};
        run_case(4'b0001, 0, 0, "limit_tie");
        fh = '{26, 11, 0, 0};
        run_case(4'b0011, 0, 0, "limit_tie2");
    endtask

    // Abort at RUN cycle 4, then a fresh run must start from a cleared count.
    task automatic test_abort();
        fh = '{2, 20, 0, 0};
        run_case(4'b0011, 4, 0, "abort");
        fh = '{6, 8, 0, 0};
        run_case(4'b0011, 0, 0, "after_abort");
    endtask

    task automatic test_abort_in_reset();
        start = 1'b1; core_mask = 4'b0001; abort = 1'b0;
        @(negedge clk);
        abort = 1'b1;   // start is still held: abort must win
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || core_rst !== '1 || done !== 1'b0 || timeout !== 1'b0 || cycle_cnt !== '0) begin
            n_fail++;
            $display("FAIL abort_reset: busy=%b core_rst=%b done=%b to=%b cnt=%0d, want 0 1111 0 0 0",
                     busy, core_rst, done, timeout, cycle_cnt);
        end
        abort = 1'b0; start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_reset_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_rst_mid_run();
        fh = '{0, 0, 0, 0};
        run_case(4'b1111, 0, 3, "rst_mid_run");
    endtask

    task automatic test_random();
        int          stop;
        bit          nd;
        int          ab;
        logic [NC-1:0] m;
        for (int n = 0; n < 40; n++) begin
            m = NC'($urandom_range(1, (1 << NC) - 1));
            for (int i = 0; i < NC; i++) fh[i] = $urandom_range(0, MAXC + 4);
            model_end(m, stop, nd);
            ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, stop) : 0;
            run_case(m, ab, 0, "random");
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; core_mask = '0; core_halt = '0;
        @(negedge clk);
        test_reset();
        test_single_done();
        test_mask_zero();
        test_single_timeout();
        test_multi_core();
        test_limit_tie();
        test_abort();
        test_abort_in_reset();
        test_rst_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
